tlb_mshr_controller: RTL

- Non-blocking successor to the single-outstanding TLB controller.
- Pipelines processor requests through a one-cycle lookup stage, so hits are served while misses are pending ("hit-under-miss").
- Tracks up to NUM_MSHR outstanding page-table-walk (PTW) misses, with tagged, out-of-order PTW responses.
- Returns one response per request on a single valid/ready port, tagged with the request ID.

---
 rtl/tlb_mshr_controller.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/tlb_mshr_controller.sv
// Non-blocking TLB miss controller: a one-cycle lookup stage with hit-under-miss,
// NUM_MSHR outstanding page-table walks with tagged out-of-order responses.
module tlb_mshr_controller #(
    parameter int unsigned VPN_W    = 20,
    parameter int unsigned ID_W     = 4,
    parameter int unsigned NUM_MSHR = 4,
    localparam int unsigned TAG_W   = (NUM_MSHR > 1) ? $clog2(NUM_MSHR) : 1,
    localparam int unsigned CNT_W   = $clog2(NUM_MSHR + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [VPN_W-1:0] req_vpn_i,
    input  logic [ID_W-1:0]  req_id_i,
    output logic             lookup_en_o,
    output logic [VPN_W-1:0] lookup_vpn_o,
    input  logic             hit_i,
    input  logic             perm_fault_i,
    output logic             ptw_req_valid_o,
    input  logic             ptw_req_ready_i,
    output logic [VPN_W-1:0] ptw_req_vpn_o,
    output logic [TAG_W-1:0] ptw_req_tag_o,
    input  logic             ptw_resp_valid_i,
    output logic             ptw_resp_ready_o,
    input  logic [TAG_W-1:0] ptw_resp_tag_i,
    input  logic             ptw_resp_fault_i,
    output logic             update_en_o,
    output logic [VPN_W-1:0] update_vpn_o,
    output logic             lru_update_en_o,
    output logic [VPN_W-1:0] lru_vpn_o,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [ID_W-1:0]  resp_id_o,
    output logic             resp_fault_o,
    output logic             resp_miss_o,
    output logic [CNT_W-1:0] mshr_busy_o,
    output logic             error_o
);

    typedef enum logic [1:0] {
        MS_FREE  = 2'd0,
        MS_ISSUE = 2'd1,
        MS_WAIT  = 2'd2,
        MS_DONE  = 2'd3
    } mshr_state_e;

    mshr_state_e      mshr_state_q [NUM_MSHR];
    mshr_state_e      mshr_state_d [NUM_MSHR];
    logic [VPN_W-1:0] mshr_vpn_q   [NUM_MSHR];
    logic [VPN_W-1:0] mshr_vpn_d   [NUM_MSHR];
    logic [ID_W-1:0]  mshr_id_q    [NUM_MSHR];
    logic [ID_W-1:0]  mshr_id_d    [NUM_MSHR];
    logic             mshr_fault_q [NUM_MSHR];
    logic             mshr_fault_d [NUM_MSHR];

    logic             lk_valid_q, lk_valid_d;
    logic [VPN_W-1:0] lk_vpn_q, lk_vpn_d;
    logic [ID_W-1:0]  lk_id_q, lk_id_d;

    logic             ptw_req_valid_d;
    logic [VPN_W-1:0] ptw_req_vpn_d;
    logic [TAG_W-1:0] ptw_req_tag_d;
    logic             update_en_d;
    logic [VPN_W-1:0] update_vpn_d;
    logic             lru_update_en_d;
    logic [VPN_W-1:0] lru_vpn_d;
    logic             resp_valid_d;
    logic [ID_W-1:0]  resp_id_d;
    logic             resp_fault_d;
    logic             resp_miss_d;
    logic [CNT_W-1:0] mshr_busy_d;
    logic             error_d;

    logic             free_found, done_found, issue_found;
    logic [TAG_W-1:0] free_idx, done_idx, issue_idx;
    logic             resp_load, lk_hit, take_lk, alloc, lk_adv;
    logic             ptw_resp_hit;

    // Lowest-index priority encoders over the current MSHR states
    always_comb begin
        free_found  = 1'b0;
        done_found  = 1'b0;
        issue_found = 1'b0;
        free_idx    = '0;
        done_idx    = '0;
        issue_idx   = '0;
        for (int i = int'(NUM_MSHR) - 1; i >= 0; i--) begin
            if (mshr_state_q[i] == MS_FREE) begin
                free_found = 1'b1;
                free_idx   = TAG_W'(i);
            end
            if (mshr_state_q[i] == MS_DONE) begin
                done_found = 1'b1;
                done_idx   = TAG_W'(i);
            end
            if (mshr_state_q[i] == MS_ISSUE) begin
                issue_found = 1'b1;
                issue_idx   = TAG_W'(i);
            end
        end
    end

    assign resp_load    = !resp_valid_o || resp_ready_i;
    assign lk_hit       = lk_valid_q && hit_i;
    assign take_lk      = resp_load && !done_found && lk_hit;
    assign alloc        = lk_valid_q && !hit_i && free_found;
    assign lk_adv       = take_lk || alloc;
    assign req_ready_o  = !rst && (!lk_valid_q || lk_adv);
    assign lookup_en_o  = req_valid_i && req_ready_o;
    assign lookup_vpn_o = req_vpn_i;

    // Next-state for lookup stage, MSHRs, PTW request and response slot
    always_comb begin
        lk_valid_d      = lk_valid_q;
        lk_vpn_d        = lk_vpn_q;
        lk_id_d         = lk_id_q;
        mshr_state_d    = mshr_state_q;
        mshr_vpn_d      = mshr_vpn_q;
        mshr_id_d       = mshr_id_q;
        mshr_fault_d    = mshr_fault_q;
        ptw_req_valid_d = ptw_req_valid_o;
        ptw_req_vpn_d   = ptw_req_vpn_o;
        ptw_req_tag_d   = ptw_req_tag_o;
        update_en_d     = 1'b0;
        update_vpn_d    = update_vpn_o;
        lru_update_en_d = 1'b0;
        lru_vpn_d       = lru_vpn_o;
        resp_valid_d    = resp_valid_o;
        resp_id_d       = resp_id_o;
        resp_fault_d    = resp_fault_o;
        resp_miss_d     = resp_miss_o;
        error_d         = error_o;
        mshr_busy_d     = '0;
        ptw_resp_hit    = 1'b0;

        if (lookup_en_o) begin
            lk_valid_d = 1'b1;
            lk_vpn_d   = req_vpn_i;
            lk_id_d    = req_id_i;
        end else if (lk_adv) begin
            lk_valid_d = 1'b0;
        end

        for (int i = 0; i < int'(NUM_MSHR); i++) begin
            if (alloc && (TAG_W'(i) == free_idx)) begin
                mshr_state_d[i] = MS_ISSUE;
                mshr_vpn_d[i]   = lk_vpn_q;
                mshr_id_d[i]    = lk_id_q;
                mshr_fault_d[i] = 1'b0;
            end
            if (ptw_req_valid_o && ptw_req_ready_i && (TAG_W'(i) == ptw_req_tag_o)) begin
                mshr_state_d[i] = MS_WAIT;
            end
            if (ptw_resp_valid_i && ptw_resp_ready_o && (TAG_W'(i) == ptw_resp_tag_i)
                && (mshr_state_q[i] == MS_WAIT)) begin
                mshr_state_d[i] = MS_DONE;
                mshr_fault_d[i] = ptw_resp_fault_i;
                ptw_resp_hit    = 1'b1;
                update_en_d     = !ptw_resp_fault_i;
                update_vpn_d    = mshr_vpn_q[i];
            end
            if (resp_load && done_found && (TAG_W'(i) == done_idx)) begin
                mshr_state_d[i] = MS_FREE;
                resp_id_d       = mshr_id_q[i];
                resp_fault_d    = mshr_fault_q[i];
                lru_update_en_d = !mshr_fault_q[i];
                lru_vpn_d       = mshr_vpn_q[i];
            end
            if (!ptw_req_valid_o && issue_found && (TAG_W'(i) == issue_idx)) begin
                ptw_req_vpn_d = mshr_vpn_q[i];
            end
        end

        // Responses to tags not awaiting a walk are a protocol violation
        if (ptw_resp_valid_i && ptw_resp_ready_o && !ptw_resp_hit) begin
            error_d = 1'b1;
        end

        if (ptw_req_valid_o && ptw_req_ready_i) begin
            ptw_req_valid_d = 1'b0;
        end else if (!ptw_req_valid_o && issue_found) begin
            ptw_req_valid_d = 1'b1;
            ptw_req_tag_d   = issue_idx;
        end

        if (resp_load) begin
            if (done_found) begin
                resp_valid_d = 1'b1;
                resp_miss_d  = 1'b1;
            end else if (lk_hit) begin
                resp_valid_d    = 1'b1;
                resp_id_d       = lk_id_q;
                resp_fault_d    = perm_fault_i;
                resp_miss_d     = 1'b0;
                lru_update_en_d = !perm_fault_i;
                lru_vpn_d       = lk_vpn_q;
            end else begin
                resp_valid_d = 1'b0;
            end
        end

        for (int i = 0; i < int'(NUM_MSHR); i++) begin
            if (mshr_state_d[i] != MS_FREE) begin
                mshr_busy_d = mshr_busy_d + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lk_valid_q       <= 1'b0;
            lk_vpn_q         <= '0;
            lk_id_q          <= '0;
            for (int i = 0; i < int'(NUM_MSHR); i++) begin
                mshr_state_q[i] <= MS_FREE;
                mshr_vpn_q[i]   <= '0;
                mshr_id_q[i]    <= '0;
                mshr_fault_q[i] <= 1'b0;
            end
            ptw_req_valid_o  <= 1'b0;
            ptw_req_vpn_o    <= '0;
            ptw_req_tag_o    <= '0;
            ptw_resp_ready_o <= 1'b0;
            update_en_o      <= 1'b0;
            update_vpn_o     <= '0;
            lru_update_en_o  <= 1'b0;
            lru_vpn_o        <= '0;
            resp_valid_o     <= 1'b0;
            resp_id_o        <= '0;
            resp_fault_o     <= 1'b0;
            resp_miss_o      <= 1'b0;
            mshr_busy_o      <= '0;
            error_o          <= 1'b0;
        end else begin
            lk_valid_q       <= lk_valid_d;
            lk_vpn_q         <= lk_vpn_d;
            lk_id_q          <= lk_id_d;
            mshr_state_q     <= mshr_state_d;
            mshr_vpn_q       <= mshr_vpn_d;
            mshr_id_q        <= mshr_id_d;
            mshr_fault_q     <= mshr_fault_d;
            ptw_req_valid_o  <= ptw_req_valid_d;
            ptw_req_vpn_o    <= ptw_req_vpn_d;
            ptw_req_tag_o    <= ptw_req_tag_d;
            ptw_resp_ready_o <= 1'b1;
            update_en_o      <= update_en_d;
            update_vpn_o     <= update_vpn_d;
            lru_update_en_o  <= lru_update_en_d;
            lru_vpn_o        <= lru_vpn_d;
            resp_valid_o     <= resp_valid_d;
            resp_id_o        <= resp_id_d;
            resp_fault_o     <= resp_fault_d;
            resp_miss_o      <= resp_miss_d;
            mshr_busy_o      <= mshr_busy_d;
            error_o          <= error_d;
        end
    end

endmodule
